// File: rtl/fifo_wr_arb_pkg.sv
// Shared definitions for the FIFO write arbiter: FSM encodings and parameter defaults.
package fifo_wr_arb_pkg;

  localparam int unsigned NREQ_DEF   = 4;
  localparam int unsigned NBIT_D_DEF = 16;
  localparam int unsigned BURST_DEF  = 8;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/fifo_wr_arb_rr_pick.sv
// Combinational round-robin pick: first requester strictly after the pointer, wrapping.
module rr_pick #(
  parameter int p_nreq = 4,
  parameter int p_nid  = 2
) (
  input  logic [p_nreq-1:0] req,
  input  logic [p_nid-1:0]  pointer,
  output logic [p_nreq-1:0] win,
  output logic [p_nid-1:0]  win_id,
  output logic              any
);

  int idx;

  // NOTE: every output gets a default before the loop so no latch can be inferred.
  always_comb begin
    win    = '0;
    win_id = '0;
    idx    = 0;
    any    = |req;
    // Scan from farthest to nearest so the nearest requester after the pointer is kept.
    for (int k = p_nreq; k >= 1; k--) begin
      idx = (int'(pointer) + k) % p_nreq;
      if (req[idx]) begin
        win      = '0;
        win[idx] = 1'b1;
        win_id   = p_nid'(idx);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin write arbiter: grants one requester at a time a burst into a shared FIFO.
module fifo_wr_arb
  import fifo_wr_arb_pkg::*;
#(
  parameter int p_nreq   = NREQ_DEF,
  parameter int p_nbit_d = NBIT_D_DEF,
  parameter int p_burst  = BURST_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [p_nreq-1:0]            req,
  input  logic [p_nreq-1:0]            last,
  input  logic [p_nreq*p_nbit_d-1:0]   wdata_in,
  output logic [p_nreq-1:0]            gnt,
  output logic [p_nreq-1:0]            ack,
  output logic                         fifo_wr,
  output logic [p_nbit_d-1:0]          fifo_wdata,
  input  logic                         fifo_full,
  output logic                         busy,
  output logic [$clog2(p_nreq)-1:0]    cur_id
);

  localparam int ID_W   = $clog2(p_nreq);
  localparam int BEAT_W = $clog2(p_burst);

  state_t              state_q, state_d;
  logic [p_nreq-1:0]   gnt_d;
  logic [ID_W-1:0]     owner_q, owner_d;
  logic [ID_W-1:0]     pointer_q, pointer_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;

  logic [p_nreq-1:0]   win;
  logic [ID_W-1:0]     win_id;
  logic                any_req;

  logic                owner_req;
  logic                owner_last;
  logic                beat_max;
  logic                burst_end;

  rr_pick #(
    .p_nreq (p_nreq),
    .p_nid  (ID_W)
  ) u_rr_pick (
    .req     (req),
    .pointer (pointer_q),
    .win     (win),
    .win_id  (win_id),
    .any     (any_req)
  );

  assign owner_req  = req[owner_q];
  assign owner_last = last[owner_q];
  assign beat_max   = (beat_q == BEAT_W'(p_burst - 1));

  assign busy       = (state_q == BUSY);
  assign fifo_wr    = busy && owner_req && !fifo_full;
  assign ack        = gnt & {p_nreq{fifo_wr}};
  assign fifo_wdata = wdata_in[owner_q*p_nbit_d +: p_nbit_d];
  assign cur_id     = owner_q;

  // Last word and beat limit on the same word fold into a single end condition.
  assign burst_end  = busy && (!owner_req || (fifo_wr && (owner_last || beat_max)));

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt;
    owner_d   = owner_q;
    pointer_d = pointer_q;
    beat_d    = beat_q;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = BUSY;
          gnt_d   = win;
          owner_d = win_id;
          beat_d  = '0;
        end
      end
      BUSY: begin
        if (fifo_wr) beat_d = beat_q + 1'b1;
        if (burst_end) begin
          state_d   = IDLE;
          gnt_d     = '0;
          pointer_d = owner_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      gnt       <= '0;
      owner_q   <= '0;
      pointer_q <= ID_W'(p_nreq - 1);
      beat_q    <= '0;
    end else begin
      state_q   <= state_d;
      gnt       <= gnt_d;
      owner_q   <= owner_d;
      pointer_q <= pointer_d;
      beat_q    <= beat_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed bench for fifo_wr_arb with 4 requesters, 16-bit data and 4-word bursts.
module tb_fifo_wr_arb;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [3:0]  last;
  logic [63:0] wdata_in;
  logic [3:0]  gnt;
  logic [3:0]  ack;
  logic        fifo_wr;
  logic [15:0] fifo_wdata;
  logic        fifo_full;
  logic        busy;
  logic [1:0]  cur_id;

  int n_checks = 0;
  int n_err    = 0;

  fifo_wr_arb #(
    .p_nreq   (4),
    .p_nbit_d (16),
    .p_burst  (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .last       (last),
    .wdata_in   (wdata_in),
    .gnt        (gnt),
    .ack        (ack),
    .fifo_wr    (fifo_wr),
    .fifo_wdata (fifo_wdata),
    .fifo_full  (fifo_full),
    .busy       (busy),
    .cur_id     (cur_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct packed {
    logic [3:0]  req;
    logic [3:0]  last;
    logic        full;
    logic [11:0] w;
    logic [3:0]  egnt;
    logic [3:0]  eack;
    logic        ewr;
    logic        ebusy;
    logic [1:0]  eid;
    logic [15:0] ewd;
  } vec_t;

  vec_t vecs [26];

  // Lane i carries {i+1, w}, so the upper nibble identifies the selected requester.
  function automatic logic [15:0] lane(input int id, input logic [11:0] w);
    return {4'(id + 1), w};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [3:0] egnt, input logic [3:0] eack,
                            input logic ewr, input logic ebusy, input logic [1:0] eid,
                            input logic [15:0] ewd);
    check($sformatf("%s gnt", tag), 32'(gnt), 32'(egnt));
    check($sformatf("%s ack", tag), 32'(ack), 32'(eack));
    check($sformatf("%s fifo_wr", tag), 32'(fifo_wr), 32'(ewr));
    check($sformatf("%s busy", tag), 32'(busy), 32'(ebusy));
    check($sformatf("%s cur_id", tag), 32'(cur_id), 32'(eid));
    check($sformatf("%s fifo_wdata", tag), 32'(fifo_wdata), 32'(ewd));
  endtask

  task automatic drive(input logic [3:0] r, input logic [3:0] l, input logic f,
                       input logic [11:0] w);
    @(negedge clk);
    req       = r;
    last      = l;
    fifo_full = f;
    for (int i = 0; i < 4; i++) wdata_in[i*16 +: 16] = lane(i, w);
    #1;
  endtask

  task automatic apply_reset();
    req       = '0;
    last      = '0;
    fifo_full = 1'b0;
    for (int i = 0; i < 4; i++) wdata_in[i*16 +: 16] = lane(i, 12'h000);
    rst_n = 1'b0;
    #1;
    check_outs("reset", 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 16'h1000);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [11:0] wv;
    int          prev;
    int          o;

    vecs = '{
      // req     last     f  w        gnt      ack      wr    busy  id     wdata
      '{4'b0001, 4'b0000, 0, 12'h000, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 16'h1000},
      '{4'b0001, 4'b0000, 0, 12'h000, 4'b0001, 4'b0001, 1'b1, 1'b1, 2'd0, 16'h1000},
      '{4'b0001, 4'b0000, 0, 12'h001, 4'b0001, 4'b0001, 1'b1, 1'b1, 2'd0, 16'h1001},
      '{4'b0001, 4'b0001, 0, 12'h002, 4'b0001, 4'b0001, 1'b1, 1'b1, 2'd0, 16'h1002},
      '{4'b0000, 4'b0000, 0, 12'h000, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 16'h1000},
      '{4'b0100, 4'b0000, 0, 12'h010, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 16'h1010},
      '{4'b0100, 4'b0000, 0, 12'h020, 4'b0100, 4'b0100, 1'b1, 1'b1, 2'd2, 16'h3020},
      '{4'b0100, 4'b0000, 1, 12'h021, 4'b0100, 4'b0000, 1'b0, 1'b1, 2'd2, 16'h3021},
      '{4'b0100, 4'b0000, 1, 12'h022, 4'b0100, 4'b0000, 1'b0, 1'b1, 2'd2, 16'h3022},
      '{4'b0100, 4'b0000, 1, 12'h023, 4'b0100, 4'b0000, 1'b0, 1'b1, 2'd2, 16'h3023},
      '{4'b0100, 4'b0000, 0, 12'h024, 4'b0100, 4'b0100, 1'b1, 1'b1, 2'd2, 16'h3024},
      '{4'b0100, 4'b0000, 0, 12'h025, 4'b0100, 4'b0100, 1'b1, 1'b1, 2'd2, 16'h3025},
      '{4'b0100, 4'b0000, 0, 12'h026, 4'b0100, 4'b0100, 1'b1, 1'b1, 2'd2, 16'h3026},
      '{4'b0100, 4'b0000, 0, 12'h027, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd2, 16'h3027},
      '{4'b0100, 4'b0000, 0, 12'h000, 4'b0100, 4'b0100, 1'b1, 1'b1, 2'd2, 16'h3000},
      '{4'b0100, 4'b0000, 0, 12'h001, 4'b0100, 4'b0100, 1'b1, 1'b1, 2'd2, 16'h3001},
      '{4'b1011, 4'b0000, 0, 12'h002, 4'b0100, 4'b0000, 1'b0, 1'b1, 2'd2, 16'h3002},
      '{4'b1011, 4'b0000, 0, 12'h003, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd2, 16'h3003},
      '{4'b1000, 4'b0000, 0, 12'h004, 4'b1000, 4'b1000, 1'b1, 1'b1, 2'd3, 16'h4004},
      '{4'b1000, 4'b0000, 0, 12'h005, 4'b1000, 4'b1000, 1'b1, 1'b1, 2'd3, 16'h4005},
      '{4'b1000, 4'b0000, 0, 12'h006, 4'b1000, 4'b1000, 1'b1, 1'b1, 2'd3, 16'h4006},
      '{4'b1000, 4'b1000, 0, 12'h007, 4'b1000, 4'b1000, 1'b1, 1'b1, 2'd3, 16'h4007},
      '{4'b0011, 4'b0000, 0, 12'h008, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd3, 16'h4008},
      '{4'b0011, 4'b0000, 0, 12'h009, 4'b0001, 4'b0001, 1'b1, 1'b1, 2'd0, 16'h1009},
      '{4'b0000, 4'b0000, 0, 12'h00a, 4'b0001, 4'b0000, 1'b0, 1'b1, 2'd0, 16'h100a},
      '{4'b0000, 4'b0000, 0, 12'h00b, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 16'h100b}
    };

    apply_reset();

    // Short burst, fifo_full stall, lone-requester regrant, owner drop, last on beat limit.
    for (int i = 0; i < 26; i++) begin
      drive(vecs[i].req, vecs[i].last, vecs[i].full, vecs[i].w);
      check_outs($sformatf("vec%0d", i), vecs[i].egnt, vecs[i].eack, vecs[i].ewr,
                 vecs[i].ebusy, vecs[i].eid, vecs[i].ewd);
    end

    // Move the pointer to 1, then start a burst for requester 3 and reset mid-burst.
    drive(4'b0010, 4'b0000, 1'b0, 12'h100);
    check_outs("pre idle", 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 16'h1100);
    drive(4'b0010, 4'b0000, 1'b0, 12'h101);
    check_outs("pre word", 4'b0010, 4'b0010, 1'b1, 1'b1, 2'd1, 16'h2101);
    drive(4'b0000, 4'b0000, 1'b0, 12'h102);
    check_outs("pre drop", 4'b0010, 4'b0000, 1'b0, 1'b1, 2'd1, 16'h2102);
    drive(4'b1000, 4'b0000, 1'b0, 12'h103);
    check_outs("abort idle", 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd1, 16'h2103);
    drive(4'b1000, 4'b0000, 1'b0, 12'h104);
    check_outs("abort w1", 4'b1000, 4'b1000, 1'b1, 1'b1, 2'd3, 16'h4104);
    drive(4'b1000, 4'b0000, 1'b0, 12'h105);
    check_outs("abort w2", 4'b1000, 4'b1000, 1'b1, 1'b1, 2'd3, 16'h4105);
    #2;
    rst_n = 1'b0;
    #1;
    check_outs("abort rst", 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 16'h1105);
    @(negedge clk);
    #1;
    check_outs("abort hold", 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 16'h1105);
    @(negedge clk);
    rst_n = 1'b1;
    req   = 4'b1010;
    #1;
    check_outs("release", 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 16'h1105);
    drive(4'b1010, 4'b0000, 1'b0, 12'h106);
    check_outs("post rst gnt", 4'b0010, 4'b0010, 1'b1, 1'b1, 2'd1, 16'h2106);

    // All four requesting: five 4-word bursts in round-robin order, one idle cycle apart.
    apply_reset();
    wv   = 12'h200;
    prev = 0;
    for (int b = 0; b < 5; b++) begin
      o = b % 4;
      drive(4'b1111, 4'b0000, 1'b0, wv);
      check_outs($sformatf("rr%0d idle", b), 4'b0000, 4'b0000, 1'b0, 1'b0, 2'(prev),
                 lane(prev, wv));
      wv++;
      for (int k = 0; k < 4; k++) begin
        drive(4'b1111, 4'b0000, 1'b0, wv);
        check_outs($sformatf("rr%0d w%0d", b, k), 4'(1 << o), 4'(1 << o), 1'b1, 1'b1,
                   2'(o), lane(o, wv));
        wv++;
      end
      prev = o;
    end
    drive(4'b1111, 4'b0000, 1'b0, wv);
    check_outs("rr end idle", 4'b0000, 4'b0000, 1'b0, 1'b0, 2'(prev), lane(prev, wv));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arb.md
FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 SHALL have parameter p_nreq, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter p_nbit_d, default 16, data width, equal to the downstream FIFO data width.
REQ-003 SHALL have parameter p_burst, default 8, max words per grant; power of 2, at least 2.
REQ-004 SHALL have ports, in this order:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  p_nreq  per-requester word-valid.
- last  in  p_nreq  per-requester end-of-burst flag, qualified by req.
- wdata_in  in  p_nreq*p_nbit_d  requester i data at bits [i*p_nbit_d +: p_nbit_d].
- gnt  out  p_nreq  one-hot grant; registered.
- ack  out  p_nreq  word accepted this cycle.
- fifo_wr  out  1  downstream FIFO write strobe.
- fifo_wdata  out  p_nbit_d  downstream FIFO write data.
- fifo_full  in  1  downstream FIFO full flag.
- busy  out  1  high in state BUSY.
- cur_id  out  clog2(p_nreq)  index of current or most recent owner.

Function
REQ-005 SHALL implement a two-state FSM, IDLE and BUSY, with state, gnt, owner, pointer and beat counter all registered.
REQ-006 In IDLE with any req high, the FSM SHALL pick a winner round-robin, starting at pointer+1 mod p_nreq, and wrap.
REQ-007 That winner SHALL load gnt and cur_id, clear the beat counter and enter BUSY on the next edge; latency from req to gnt is 1 cycle.
REQ-008 In IDLE with no req, gnt SHALL remain 0 and the state SHALL remain IDLE.
REQ-009 In BUSY, fifo_wr SHALL equal req[owner] AND NOT fifo_full, combinationally.
REQ-010 In BUSY, fifo_wdata SHALL be the owner's data slice, combinationally.
REQ-011 ack[owner] SHALL equal fifo_wr; all other ack bits SHALL be 0.
REQ-012 Outside BUSY, fifo_wr and ack SHALL be 0 and fifo_wdata SHALL be held at the owner slice.
REQ-013 Each accepted word SHALL increment the beat counter; the counter is clog2(p_burst) bits and wraps.
REQ-014 BUSY SHALL end, returning to IDLE, clearing gnt and setting pointer to owner, on whichever comes first:
- an accepted word with last[owner]=1;
- an accepted word with beat counter = p_burst-1;
- req[owner]=0 during a cycle.
REQ-015 When last and the beat limit coincide on one word, the FSM SHALL perform exactly one burst end.
REQ-016 With fifo_full high, no word SHALL be accepted, the beat counter SHALL hold and the grant SHALL be kept while req[owner] stays high.
REQ-017 Exactly one IDLE cycle SHALL separate consecutive bursts; gnt SHALL never have more than one bit set.
REQ-018 Requests from non-owners SHALL be ignored (not acked) until re-arbitration.
REQ-019 A requester that is the only one requesting SHALL win again after its own burst end.

Reset
REQ-020 rst_n low SHALL asynchronously force:
- state to IDLE, with busy low;
- gnt, ack and fifo_wr to 0;
- beat counter and cur_id to 0;
- pointer to p_nreq-1, so requester 0 has first priority.
REQ-021 Reset asserted mid-burst SHALL abort the burst with no further fifo_wr; there is no partial-burst recovery.
REQ-022 After release, the first arbitration SHALL occur on the first rising edge with rst_n high.

Structure
REQ-023 A shared package SHALL hold the FSM state encodings (IDLE=0, BUSY=1) and the parameter defaults.
REQ-024 Round-robin selection SHALL be one combinational sub-module, rr_pick, with inputs req and pointer and outputs a one-hot winner, its index and an any-request flag.
REQ-025 fifo_wr_arb SHALL contain the FSM, beat counter, data mux and pointer.

Verification (p_nreq=4, p_burst=4, p_nbit_d=16)
REQ-026 Reset release, then req=0001 with data 0x1000..0x1002 and last on the third word:
- gnt=0001 one cycle after req;
- three fifo_wr pulses carrying 0x1000, 0x1001, 0x1002;
- gnt=0 on the cycle after the last word.
REQ-027 req=1111 held, all last=0: grants cycle 0001, 0010, 0100, 1000, 0001, each exactly 4 words with 1 idle cycle between bursts.
REQ-028 fifo_full high for 3 cycles mid-burst: fifo_wr and ack stay 0 for those cycles, the grant is held, the beat count is unchanged and the burst still totals 4 words.
REQ-029 Owner drops req after 2 words: the burst ends, and the next requester in round-robin order is granted after one IDLE cycle.
REQ-030 rst_n asserted during word 2 of a burst: gnt, fifo_wr and busy go to 0 immediately; after release, req=1010 grants 0010 first.
REQ-031 last and the 4th word coincide: a single burst end, with no double pointer advance.
